// File: rtl/aes_128_key_expand.sv
// aes_128_key_expand: AES-128 key schedule streaming round keys 0..10 as 64-bit key RAM writes.
// Define AES_KEXP_FAST_EN to derive the next key during the low write (2 cycles per round instead of 3).
module aes_128_key_expand #(
    parameter int unsigned ADDR_BASE = 0
) (
    input  logic         clk,
    input  logic         kill,
    input  logic [127:0] key_in,
    input  logic         key_en,
    output logic         en_wr,
    output logic [4:0]   addr_wr,
    output logic [63:0]  key_round_wr,
    output logic         busy,
    output logic         done
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [1:10][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    localparam logic [4:0] BASE = 5'(ADDR_BASE);

    typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, CALC, DONE} state_t;

    state_t       state;
    logic [3:0]   round;
    logic [127:0] rk;
    logic [127:0] rk_next;
    logic [3:0]   round_nx;
    logic [31:0]  rot, sub, w0n, w1n, w2n, w3n;

    // Next round key from the current one; rcon index is the round being produced.
    always_comb begin
        round_nx = round + 4'd1;
        rot      = {rk[23:0], rk[31:24]};
        sub      = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
        w0n      = rk[127:96] ^ sub ^ {RCON[round_nx], 24'h0};
        w1n      = rk[95:64] ^ w0n;
        w2n      = rk[63:32] ^ w1n;
        w3n      = rk[31:0] ^ w2n;
        rk_next  = {w0n, w1n, w2n, w3n};
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            state        <= IDLE;
            round        <= '0;
            rk           <= '0;
            en_wr        <= 1'b0;
            addr_wr      <= '0;
            key_round_wr <= '0;
            done         <= 1'b0;
        end else begin
            en_wr        <= 1'b0;
            addr_wr      <= '0;
            key_round_wr <= '0;
            done         <= 1'b0;
            case (state)
                IDLE: if (key_en) begin
                    rk    <= key_in;
                    round <= '0;
                    state <= WR_HI;
                end
                WR_HI: begin
                    en_wr        <= 1'b1;
                    addr_wr      <= BASE + {round, 1'b0};
                    key_round_wr <= rk[127:64];
                    state        <= WR_LO;
                end
                WR_LO: begin
                    en_wr        <= 1'b1;
                    addr_wr      <= BASE + {round, 1'b1};
                    key_round_wr <= rk[63:0];
                    if (round == 4'd10) state <= DONE;
                    else begin
`ifdef AES_KEXP_FAST_EN
                        rk    <= rk_next;
                        round <= round_nx;
                        state <= WR_HI;
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    rk    <= rk_next;
                    round <= round_nx;
                    state <= WR_HI;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
